axi_lite_burst_master: RTL

Burst initiator for the 8-bit-address memory slave's five-channel valid/ready bus (AR/R read path, AW/W/B write path). Accepts one read or write command at a time from a local controller, performs the address handshake, moves 1–15 data beats, checks response framing and IDs, and reports a single completion status. Write data is staged beforehand in an internal 16×8 buffer; read data is streamed out one beat per accepted R transfer.

---
 rtl/axi_lite_burst_master.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_burst_master.sv
// rtl/axi_lite_burst_master.sv - single-command burst initiator for the five-channel memory slave bus
// Write data is staged in a 16x8 buffer; read beats stream out as one-cycle pulses.
module axi_lite_burst_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [3:0]  cmd_id,
  input  logic        wbuf_we,
  input  logic [3:0]  wbuf_addr,
  input  logic [7:0]  wbuf_data,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic [15:0] ARIN,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [8:0]  RDATA,
  input  logic        RLAST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [11:0] AWIN,
  output logic        WVALID,
  input  logic        WREADY,
  output logic [7:0]  WDATA,
  output logic        WLAST,
  input  logic        BVALID,
  output logic        BREADY,
  input  logic [4:0]  BRESP,
  output logic        rdat_valid,
  output logic [7:0]  rdat_data,
  output logic        rdat_err,
  output logic        rdat_last,
  output logic        done,
  output logic        done_err,
  output logic [3:0]  done_id
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

  state_t        state, state_nx;
  logic [7:0]    addr_q, addr_nx;
  logic [3:0]    len_q, len_nx;
  logic [3:0]    id_q, id_nx;
  logic [3:0]    beat_q, beat_nx;
  logic          err_q, err_nx;
  logic [TW-1:0] tcnt_q;
  logic [7:0]    wbuf [16];

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, any_hs, busy, last_beat, timeout_hit;

  // Handshakes are judged against the registered VALID/READY the slave actually sees.
  assign ar_hs       = ARVALID & ARREADY;
  assign r_hs        = RREADY & RVALID;
  assign aw_hs       = AWVALID & AWREADY;
  assign w_hs        = WVALID & WREADY;
  assign b_hs        = BREADY & BVALID;
  assign any_hs      = ar_hs | r_hs | aw_hs | w_hs | b_hs;
  assign busy        = (state == S_AR) || (state == S_R) || (state == S_AW) ||
                       (state == S_W) || (state == S_B);
  assign last_beat   = (beat_q == len_q - 4'd1);
  assign timeout_hit = busy && !any_hs && (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    len_nx   = len_q;
    id_nx    = id_q;
    beat_nx  = beat_q;
    err_nx   = err_q;
    case (state)
      S_IDLE: if (cmd_valid) begin
        addr_nx  = cmd_addr;
        len_nx   = cmd_len;
        id_nx    = cmd_id;
        beat_nx  = 4'd0;
        err_nx   = (cmd_len == 4'd0);
        state_nx = (cmd_len == 4'd0) ? S_DONE : (cmd_write ? S_AW : S_AR);
      end
      S_AR: if (ar_hs) state_nx = S_R;
      S_R: if (r_hs) begin
        beat_nx = beat_q + 4'd1;
        err_nx  = err_q | RDATA[0] | (RLAST != last_beat);
        if (last_beat) state_nx = S_DONE;
      end
      S_AW: if (aw_hs) state_nx = S_W;
      S_W: if (w_hs) begin
        beat_nx = beat_q + 4'd1;
        if (last_beat) state_nx = S_B;
      end
      S_B: if (b_hs) begin
        err_nx   = err_q | BRESP[4] | (BRESP[3:0] != id_q);
        state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_nx = S_DONE;
      err_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
      tcnt_q <= '0;
    end else begin
      addr_q <= addr_nx;
      len_q  <= len_nx;
      id_q   <= id_nx;
      beat_q <= beat_nx;
      err_q  <= err_nx;
      tcnt_q <= (!busy || any_hs) ? '0 : tcnt_q + 1'b1;
    end
  end

  // Buffer has no reset so staged write data survives a mid-burst reset.
  always_ff @(posedge clk) begin
    if (wbuf_we && state != S_W) wbuf[wbuf_addr] <= wbuf_data;
  end

  logic        cmd_ready_d, arvalid_d, rready_d, awvalid_d, wvalid_d, wlast_d, bready_d;
  logic        rdat_valid_d, rdat_err_d, rdat_last_d, done_d, done_err_d;
  logic [15:0] arin_d;
  logic [11:0] awin_d;
  logic [7:0]  wdata_d, rdat_data_d;
  logic [3:0]  done_id_d;

  // Outputs are decoded from the next state so the registered bus reflects the state entered at each edge.
  always_comb begin
    cmd_ready_d  = (state_nx == S_IDLE);
    arvalid_d    = (state_nx == S_AR);
    arin_d       = (state_nx == S_AR) ? {addr_nx, len_nx, id_nx} : 16'd0;
    rready_d     = (state_nx == S_R);
    awvalid_d    = (state_nx == S_AW);
    awin_d       = (state_nx == S_AW) ? {addr_nx, id_nx} : 12'd0;
    wvalid_d     = (state_nx == S_W);
    wdata_d      = (state_nx == S_W) ? wbuf[beat_nx] : 8'd0;
    wlast_d      = (state_nx == S_W) && (beat_nx == len_nx - 4'd1);
    bready_d     = (state_nx == S_B);
    rdat_valid_d = r_hs;
    rdat_data_d  = r_hs ? RDATA[8:1] : 8'd0;
    rdat_err_d   = r_hs & RDATA[0];
    rdat_last_d  = r_hs & RLAST;
    done_d       = (state_nx == S_DONE);
    done_err_d   = (state_nx == S_DONE) & err_nx;
    done_id_d    = (state_nx == S_DONE) ? id_nx : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready  <= 1'b0;
      ARVALID    <= 1'b0;
      ARIN       <= '0;
      RREADY     <= 1'b0;
      AWVALID    <= 1'b0;
      AWIN       <= '0;
      WVALID     <= 1'b0;
      WDATA      <= '0;
      WLAST      <= 1'b0;
      BREADY     <= 1'b0;
      rdat_valid <= 1'b0;
      rdat_data  <= '0;
      rdat_err   <= 1'b0;
      rdat_last  <= 1'b0;
      done       <= 1'b0;
      done_err   <= 1'b0;
      done_id    <= '0;
    end else begin
      cmd_ready  <= cmd_ready_d;
      ARVALID    <= arvalid_d;
      ARIN       <= arin_d;
      RREADY     <= rready_d;
      AWVALID    <= awvalid_d;
      AWIN       <= awin_d;
      WVALID     <= wvalid_d;
      WDATA      <= wdata_d;
      WLAST      <= wlast_d;
      BREADY     <= bready_d;
      rdat_valid <= rdat_valid_d;
      rdat_data  <= rdat_data_d;
      rdat_err   <= rdat_err_d;
      rdat_last  <= rdat_last_d;
      done       <= done_d;
      done_err   <= done_err_d;
      done_id    <= done_id_d;
    end
  end

endmodule
